pll_reconfig_ctrl: RTL
======================

# pll_reconfig_ctrl

Sequencer that reprograms the SDRAM clock PLL through its Avalon-MM reconfiguration port. Given a 6-bit frequency-step index, it looks up M/K/C0 values in a 64-entry table, issues the write sequence, pulses the PLL reset, and waits for lock with a timeout. It sits between the frequency-selection logic (keyboard/joystick/auto-step) and `pll_cfg`, all on CLK_50M. It replaces the ad-hoc 8-cycle-slot write loop with a proper waitrequest handshake.

## Interface
Parameters:
- GAP_CYCLES, 8: idle cycles after each completed write (≥1).
- RST_CYCLES, 8: width of the pll_reset pulse in cycles (≥1).
- LOCK_TIMEOUT, 5000000: cycles allowed for relock (100 ms).

Ports:
- CLK_50M  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- req  in  1  one-cycle request to reprogram.
- idx  in  6  frequency-step index, sampled with req.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at sequence end.
- error  out  1  lock timeout on the last sequence; sticky.
- freq_bcd  out  12  BCD MHz code of the currently latched index.
- mgmt_waitrequest  in  1  reconfig port stall.
- mgmt_write  out  1  write strobe.
- mgmt_address  out  6  register address.
- mgmt_writedata  out  32  register data.
- pll_reset  out  1  PLL reset.
- locked  in  1  PLL lock (already synchronous to CLK_50M).

## Operation
- Reset values: busy, done, error, mgmt_write, and pll_reset = 0. mgmt_address and mgmt_writedata = 0. Latched index = 0, so freq_bcd = entry 0.
- State machine: IDLE → WRITE ⇄ GAP → PRST → LOCKWAIT → DONE → IDLE.
- **IDLE:** when req=1, latch idx, clear error, and go to WRITE with write pointer 0.
- **Write list, in order:**
  - mode (addr 0, data 0)
  - M (addr 4, entry.m)
  - K (addr 7, entry.k)
  - N (addr 3, data 'h10000)
  - C0 (addr 5, entry.c0)
  - [charge pump (addr 9, data 1), bandwidth (addr 8, data 7)], see Configuration
  - start (addr 2, data 0)
- **WRITE:** hold mgmt_write=1 and address/data stable until an edge where mgmt_waitrequest=0. That edge completes the write. Then go to GAP.
- **GAP:** GAP_CYCLES cycles with mgmt_write=0. Then go to the next WRITE, or to PRST after the start write.
- **PRST:** pll_reset=1 for exactly RST_CYCLES cycles.
- **LOCKWAIT:** the counter clears on entry and increments every cycle.
  - locked=1 sampled → DONE.
  - Counter reaches LOCK_TIMEOUT−1 with locked still low → set error, then DONE.
- **DONE:** done=1 for one cycle. Then go to IDLE, or directly to WRITE if a request is pending.
- **req while busy:** stored in a one-deep pending slot; a later req overwrites the stored idx (last one wins). When that request starts, idx is re-latched and error is cleared.
- **req on the same edge DONE exits:** treated as pending, so it is serviced immediately.
- **RESET mid-sequence:**
  - Return to IDLE on the next edge.
  - Drop pll_reset and mgmt_write immediately.
  - Discard the pending request.
  - Clear error.

## Timing
- req on edge 0 → busy=1 and the first mgmt_write on cycle 1.
- With waitrequest held 0, write k asserts at cycle 1 + k·(1+GAP_CYCLES).
- pll_reset rises GAP_CYCLES+1 cycles after the last write's mgmt_write cycle.
- done rises the cycle after locked is sampled high. busy falls together with done.
- freq_bcd updates the cycle after the index is latched. It comes from a registered table lookup, so entry data is valid before the first write.

## Configuration
- Macro: `PLLRECFG_BANDWIDTH_EN`.
  - Defined: charge-pump and bandwidth writes are included (8 writes).
  - Undefined: both writes and their GAPs are skipped (6 writes); PLL keeps its compiled bandwidth.

## Structure
- Package `pll_recfg_pkg` holds:
  - register address constants (MODE, M, K, N, C0, CP, BW, START)
  - typedef `pll_cfg_entry_t` {freq_bcd[11:0], m[31:0], k[31:0], c0[31:0]}
  - the state enum
  - the N constant 'h10000
- Sub-module `pll_cfg_rom`: a 64-entry synchronous lookup, idx → `pll_cfg_entry_t`, holding the frequency table.

## Test plan
- Index 5, waitrequest=0, locked returns 20 cycles after PRST ends, macro on → 8 writes at cycles 1, 10, 19, …, 64. pll_reset high for 8 cycles. done once. error=0. freq_bcd='h145.
- waitrequest held high 3 cycles on the M write → mgmt_write high 4 cycles with address 4 and data stable throughout. Later writes shift by 3 cycles.
- locked stays 0 → error=1 and done exactly LOCK_TIMEOUT cycles after LOCKWAIT entry. error clears on the next req.
- req idx=3 then idx=7 while busy → the second sequence runs with index 7 right after done, with no IDLE cycle. Index 3 is not rerun.
- RESET asserted during PRST → pll_reset=0 and busy=0 the next cycle. No done. The pending request is lost.
- Macro off → only addresses 0, 4, 7, 3, 5, 2 are written, and no write to 8 or 9 occurs.

Source files
------------

// File: rtl/pll_recfg_pkg.sv
// pll_recfg_pkg: register map, table entry type, FSM states and the frequency table builder.
package pll_recfg_pkg;
  localparam logic [5:0] A_MODE = 6'd0, A_M = 6'd4, A_K = 6'd7, A_N = 6'd3;
  localparam logic [5:0] A_C0 = 6'd5, A_CP = 6'd9, A_BW = 6'd8, A_START = 6'd2;
  localparam logic [31:0] N_VAL = 32'h10000;
  typedef struct packed {
    logic [11:0] freq_bcd;
    logic [31:0] m;
    logic [31:0] k;
    logic [31:0] c0;
  } pll_cfg_entry_t;
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_GAP, S_PRST, S_LOCKWAIT, S_DONE} state_t;
  // Counter word: {odd, bypass, high count, low count}.
  function automatic logic [31:0] cnt_enc(input int unsigned n);
    return {14'd0, n[0], n == 1, 8'(n - n / 2), 8'(n / 2)};
  endfunction
  // Step i runs at 120+5i MHz; VCO = f*d from the 50 MHz reference, the fractional part of M goes to K.
  function automatic pll_cfg_entry_t make_entry(input int unsigned i);
    pll_cfg_entry_t e;
    int unsigned f, d, v;
    f = 120 + 5 * i;
    d = f < 200 ? 6 : f < 300 ? 4 : 3;
    v = f * d;
    e.freq_bcd = {4'(f / 100), 4'(f / 10 % 10), 4'(f % 10)};
    e.m = cnt_enc(v / 50);
    e.k = 32'((64'(v % 50) << 32) / 64'd50);
    e.c0 = cnt_enc(d);
    return e;
  endfunction
  function automatic logic [31:0] reg_data(input logic [5:0] a, input pll_cfg_entry_t e);
    return a == A_M ? e.m : a == A_K ? e.k : a == A_N ? N_VAL : a == A_C0 ? e.c0 :
           a == A_CP ? 32'd1 : a == A_BW ? 32'd7 : 32'd0;
  endfunction
endpackage

// File: rtl/pll_cfg_rom.sv
// pll_cfg_rom: 64-entry registered lookup from frequency-step index to PLL settings.
module pll_cfg_rom
  import pll_recfg_pkg::*;
(
  input  logic           CLK_50M,
  input  logic           RESET,
  input  logic [5:0]     idx,
  output pll_cfg_entry_t q
);
  pll_cfg_entry_t tbl [64];
  for (genvar i = 0; i < 64; i++) begin : g_tbl
    assign tbl[i] = make_entry(i);
  end
  always_ff @(posedge CLK_50M) q <= RESET ? tbl[0] : tbl[idx];
endmodule

// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: PLL reconfiguration sequencer with waitrequest handshake, reset pulse and lock timeout.
// Define PLLRECFG_BANDWIDTH_EN to also write the charge-pump and bandwidth registers.
module pll_reconfig_ctrl
  import pll_recfg_pkg::*;
#(
  parameter int GAP_CYCLES   = 8,
  parameter int RST_CYCLES   = 8,
  parameter int LOCK_TIMEOUT = 5000000
) (
  input  logic        CLK_50M,
  input  logic        RESET,
  input  logic        req,
  input  logic [5:0]  idx,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [11:0] freq_bcd,
  input  logic        mgmt_waitrequest,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        pll_reset,
  input  logic        locked
);
`ifdef PLLRECFG_BANDWIDTH_EN
  localparam int NW = 8;
  localparam logic [5:0] WR_LIST [8] = '{A_MODE, A_M, A_K, A_N, A_C0, A_CP, A_BW, A_START};
`else
  localparam int NW = 6;
  localparam logic [5:0] WR_LIST [8] = '{A_MODE, A_M, A_K, A_N, A_C0, A_START, A_START, A_START};
`endif
  localparam logic [2:0] LAST = 3'(NW - 1);
  state_t         st;
  pll_cfg_entry_t ent;
  logic [5:0]     idx_q, pend_idx, start_idx, nxt_addr;
  logic [31:0]    cnt, nxt_data;
  logic [2:0]     ptr, wp;
  logic           pend, start;
  pll_cfg_rom u_rom (.CLK_50M(CLK_50M), .RESET(RESET), .idx(idx_q), .q(ent));
  assign freq_bcd = ent.freq_bcd;
  // A req arriving as DONE exits is serviced directly, same as a stored one.
  always_comb begin
    start     = req ? (st == S_IDLE || st == S_DONE) : (st == S_DONE && pend);
    start_idx = req ? idx : pend_idx;
    wp        = start ? 3'd0 : ptr + 3'd1;
    nxt_addr  = WR_LIST[wp];
    nxt_data  = reg_data(nxt_addr, ent);
  end
  always_ff @(posedge CLK_50M) begin
    if (RESET) begin
      st             <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      mgmt_write     <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
      pll_reset      <= 1'b0;
      idx_q          <= '0;
      pend           <= 1'b0;
      pend_idx       <= '0;
      ptr            <= '0;
      cnt            <= '0;
    end else begin
      done <= 1'b0;
      if (req && busy) begin
        pend     <= 1'b1;
        pend_idx <= idx;
      end
      unique case (st)
        S_IDLE, S_DONE: begin
          st <= S_IDLE;
          if (start) begin
            st             <= S_WRITE;
            idx_q          <= start_idx;
            error          <= 1'b0;
            pend           <= 1'b0;
            busy           <= 1'b1;
            ptr            <= 3'd0;
            mgmt_write     <= 1'b1;
            mgmt_address   <= nxt_addr;
            mgmt_writedata <= nxt_data;
          end
        end
        S_WRITE: if (!mgmt_waitrequest) begin
          mgmt_write <= 1'b0;
          cnt        <= '0;
          st         <= S_GAP;
        end
        S_GAP: begin
          cnt <= cnt + 32'd1;
          if (cnt == 32'(GAP_CYCLES - 1)) begin
            cnt <= '0;
            if (ptr == LAST) begin
              st        <= S_PRST;
              pll_reset <= 1'b1;
            end else begin
              st             <= S_WRITE;
              ptr            <= wp;
              mgmt_write     <= 1'b1;
              mgmt_address   <= nxt_addr;
              mgmt_writedata <= nxt_data;
            end
          end
        end
        S_PRST: begin
          cnt <= cnt + 32'd1;
          if (cnt == 32'(RST_CYCLES - 1)) begin
            cnt       <= '0;
            pll_reset <= 1'b0;
            st        <= S_LOCKWAIT;
          end
        end
        S_LOCKWAIT: begin
          cnt <= cnt + 32'd1;
          if (locked || cnt == 32'(LOCK_TIMEOUT - 1)) begin
            error <= !locked;
            done  <= 1'b1;
            busy  <= 1'b0;
            st    <= S_DONE;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end
endmodule
